audio_i2s_tx: RTL and testbench

- Downstream consumer of the 32-bit audio sample FIFO.
- Pops stereo samples: [31:16] = left, [15:0] = right, 16-bit two's complement.
- Serialises samples as Philips I2S master: generates BCLK and LRCLK from clk_i and drives SDATA to an external DAC.
- Holds one sample in reserve so FIFO read latency never causes an underrun, and reports underruns to the controller.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_i2s_clkgen.sv | 43 ++++
 rtl/audio_i2s_tx.sv | 108 ++++++++++
 tb/tb_audio_i2s_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants: I2S frame geometry and the stereo channel bit ranges
// agreed with the FIFO producer side.
package audio_pkg;

    localparam int unsigned I2S_FRAME_BITS = 32;
    localparam int unsigned I2S_CH_BITS    = 16;

    localparam int unsigned LEFT_MSB  = 31;
    localparam int unsigned LEFT_LSB  = 16;
    localparam int unsigned RIGHT_MSB = 15;
    localparam int unsigned RIGHT_LSB = 0;

    typedef logic [4:0] bit_cnt_t;

    localparam bit_cnt_t BIT_CNT_LAST   = 5'd31;
    localparam bit_cnt_t LR_RIGHT_FIRST = 5'd15;
    localparam bit_cnt_t LR_RIGHT_LAST  = 5'd30;

    // Word select leads the channel MSB by one bit (Philips I2S delay).
    function automatic logic lrclk_for_bit(input bit_cnt_t bit_idx);
        return (bit_idx >= LR_RIGHT_FIRST) && (bit_idx <= LR_RIGHT_LAST);
    endfunction

endpackage

// File: rtl/audio_i2s_clkgen.sv
// BCLK generator: divides clk_i by 2*CLK_DIV and strobes the cycle on which
// BCLK is about to fall.
module audio_i2s_clkgen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DIV_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_enable,
    output logic o_bclk,
    output logic o_fall
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_bclk;
    logic             w_term;

    assign w_term = (r_div == DIV_LAST);

    // Half-period divider; BCLK toggles on each terminal count while enabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (!i_enable) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_term) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    assign o_bclk = r_bclk;
    assign o_fall = i_enable & w_term & r_bclk;

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S master transmitter: pops stereo samples from the FIFO into a
// one-deep hold slot and shifts them out MSB first on BCLK falling edges.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DIV_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        inport_valid_i,
    input  logic [31:0] inport_data_i,
    output logic        inport_pop_o,
    output logic        i2s_bclk_o,
    output logic        i2s_lrclk_o,
    output logic        i2s_sdata_o,
    output logic        underrun_o
);

    logic                      r_hold_valid;
    logic [I2S_FRAME_BITS-1:0] r_hold;
    logic [I2S_FRAME_BITS-1:0] r_shift;
    bit_cnt_t                  r_bit_cnt;
    logic                      r_lrclk;
    logic                      r_sdata;
    logic                      r_underrun;

    logic                      w_bclk;
    logic                      w_fall;
    logic                      w_pop;
    logic                      w_frame_start;
    bit_cnt_t                  w_next_cnt;
    logic [I2S_FRAME_BITS-1:0] w_next_shift;

    audio_i2s_clkgen #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_clkgen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_enable (enable_i),
        .o_bclk   (w_bclk),
        .o_fall   (w_fall)
    );

    // Refill only into an empty slot, so a frame-start load never races a pop.
    assign w_pop         = enable_i & ~r_hold_valid & inport_valid_i;
    assign w_next_cnt    = r_bit_cnt + 5'd1;
    assign w_frame_start = (w_next_cnt == 5'd0);

    // Next shift register content for a falling event.
    always_comb begin
        w_next_shift = r_shift;
        if (w_frame_start) begin
            if (r_hold_valid) begin
                w_next_shift = r_hold;
            end else begin
                w_next_shift = '0;
            end
        end else begin
            w_next_shift = {r_shift[I2S_FRAME_BITS-2:0], 1'b0};
        end
    end

    // Hold slot, bit counter and serial outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_shift      <= '0;
            r_bit_cnt    <= BIT_CNT_LAST;
            r_lrclk      <= 1'b0;
            r_sdata      <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (!enable_i) begin
                r_bit_cnt <= BIT_CNT_LAST;
                r_lrclk   <= 1'b0;
                r_sdata   <= 1'b0;
            end else if (w_fall) begin
                r_bit_cnt <= w_next_cnt;
                r_shift   <= w_next_shift;
                r_sdata   <= w_next_shift[I2S_FRAME_BITS-1];
                r_lrclk   <= lrclk_for_bit(w_next_cnt);
                if (w_frame_start) begin
                    if (r_hold_valid) begin
                        r_hold_valid <= 1'b0;
                    end else begin
                        r_underrun <= 1'b1;
                    end
                end
            end
            if (w_pop) begin
                r_hold_valid <= 1'b1;
                r_hold       <= inport_data_i;
            end
        end
    end

    assign inport_pop_o = w_pop;
    assign i2s_bclk_o   = w_bclk;
    assign i2s_lrclk_o  = r_lrclk;
    assign i2s_sdata_o  = r_sdata;
    assign underrun_o   = r_underrun;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench: two transmitters (CLK_DIV 4 and 1) compared every cycle
// against a time-based frame model of the I2S output.
module tb_audio_i2s_tx;

    localparam int CD0 = 4;
    localparam int CD1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en0 = 1'b0, en1 = 1'b0;
    logic        val0 = 1'b0, val1 = 1'b0;
    logic [31:0] dat0 = 32'd0, dat1 = 32'd0;
    logic        pop0, pop1, bclk0, bclk1, lr0, lr1, sd0, sd1, und0, und1;

    always #5 clk = ~clk;

    audio_i2s_tx #(.CLK_DIV(CD0), .DIV_W(8)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .enable_i(en0),
        .inport_valid_i(val0), .inport_data_i(dat0), .inport_pop_o(pop0),
        .i2s_bclk_o(bclk0), .i2s_lrclk_o(lr0), .i2s_sdata_o(sd0), .underrun_o(und0)
    );

    audio_i2s_tx #(.CLK_DIV(CD1), .DIV_W(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1),
        .inport_valid_i(val1), .inport_data_i(dat1), .inport_pop_o(pop1),
        .i2s_bclk_o(bclk1), .i2s_lrclk_o(lr1), .i2s_sdata_o(sd1), .underrun_o(und1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: per instance, enabled-cycle count since enable, the
    // one-deep hold slot and the sample currently being transmitted.
    int          cdiv[2] = '{CD0, CD1};
    int          m_t[2];
    bit          m_hv[2];
    logic [31:0] m_hold[2];
    logic [31:0] m_cur[2];
    bit          m_und[2];
    bit          p_en[2], p_val[2];
    logic [31:0] p_dat[2];
    bit          p_rst = 1'b1;
    int          und_cnt[2];
    int          pop_cnt[2];

    task automatic model_reset(input int i);
        m_t[i] = 0; m_hv[i] = 1'b0; m_hold[i] = 32'd0; m_cur[i] = 32'd0; m_und[i] = 1'b0;
    endtask

    task automatic model_edge(input int i);
        bit do_pop;
        int f;
        do_pop   = p_en[i] && !m_hv[i] && p_val[i];
        m_und[i] = 1'b0;
        if (p_en[i]) begin
            m_t[i]++;
            if (m_t[i] % (2 * cdiv[i]) == 0) begin
                f = m_t[i] / (2 * cdiv[i]);
                if ((f - 1) % 32 == 0) begin
                    if (m_hv[i]) begin
                        m_cur[i] = m_hold[i];
                        m_hv[i]  = 1'b0;
                    end else begin
                        m_cur[i] = 32'd0;
                        m_und[i] = 1'b1;
                    end
                end
            end
        end else begin
            m_t[i] = 0;
        end
        if (do_pop) begin
            m_hv[i]   = 1'b1;
            m_hold[i] = p_dat[i];
        end
    endtask

    task automatic compare(input int i, input logic en, input logic val, input logic pop,
                           input logic bclk, input logic lr, input logic sd, input logic und);
        int   f, k;
        logic e_bclk, e_lr, e_sd, e_pop;
        f      = m_t[i] / (2 * cdiv[i]);
        k      = (f + 31) % 32;
        e_bclk = ((m_t[i] / cdiv[i]) % 2) == 1;
        e_sd   = (f == 0) ? 1'b0 : m_cur[i][31-k];
        e_lr   = (f == 0) ? 1'b0 : ((k >= 15) && (k <= 30));
        e_pop  = en & ~m_hv[i] & val;
        check_eq($sformatf("pop%0d", i),   pop,  e_pop);
        check_eq($sformatf("bclk%0d", i),  bclk, e_bclk);
        check_eq($sformatf("lrclk%0d", i), lr,   e_lr);
        check_eq($sformatf("sdata%0d", i), sd,   e_sd);
        check_eq($sformatf("underrun%0d", i), und, m_und[i]);
        if (und === 1'b1) und_cnt[i]++;
        if ((pop & val) === 1'b1) pop_cnt[i]++;
    endtask

    // Monitor: at each falling clk edge apply the preceding rising edge to the
    // model, then compare every output of both instances.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else if (!p_rst) model_edge(i);
        end
        compare(0, en0, val0, pop0, bclk0, lr0, sd0, und0);
        compare(1, en1, val1, pop1, bclk1, lr1, sd1, und1);
        p_en[0] = en0; p_val[0] = val0; p_dat[0] = dat0;
        p_en[1] = en1; p_val[1] = val1; p_dat[1] = dat1;
        p_rst = rst;
    end

    // FIFO stand-in for instance 0: presents the queue head, advances on a transfer.
    logic [31:0] q0[$];
    bit          popped0;
    initial forever begin
        @(negedge clk);
        popped0 = (pop0 & val0) === 1'b1;
        @(posedge clk);
        #1;
        if (popped0 && q0.size() > 0) void'(q0.pop_front());
        val0 = q0.size() > 0;
        dat0 = (q0.size() > 0) ? q0[0] : $urandom;
    end

    // Instance 1 source: valid for one cycle every 40, fresh random data every cycle.
    bit g_on = 1'b0;
    int g_cnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        dat1 = $urandom;
        if (g_on) begin
            en1  = 1'b1;
            val1 = (g_cnt % 40 == 0);
            g_cnt++;
        end else begin
            en1   = 1'b0;
            val1  = 1'b0;
            g_cnt = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int u0, p0, u1;

    initial begin
        step(3);
        check_eq("rst_bclk", bclk0, 1'b0);
        check_eq("rst_lrclk", lr0, 1'b0);
        check_eq("rst_sdata", sd0, 1'b0);
        check_eq("rst_underrun", und0, 1'b0);
        rst = 1'b0;
        step(2);

        // One sample, fixed pattern
        p0 = pop_cnt[0];
        q0.push_back(32'hA5A5_0F0F);
        en0 = 1'b1;
        step(300);
        check_eq("t1_pops", pop_cnt[0] - p0, 1);
        en0 = 1'b0;
        step(4);

        // Empty FIFO for two frames
        u0 = und_cnt[0]; p0 = pop_cnt[0];
        en0 = 1'b1;
        step(512);
        check_eq("t2_underruns", und_cnt[0] - u0, 2);
        check_eq("t2_pops", pop_cnt[0] - p0, 0);
        en0 = 1'b0;
        step(4);

        // Sparse valid, CLK_DIV=1
        u1 = und_cnt[1];
        g_on = 1'b1;
        step(600);
        check_eq("t4_underruns", und_cnt[1] - u1, 0);
        check_eq("t4_some_pops", pop_cnt[1] > 0, 1'b1);
        g_on = 1'b0;
        step(4);

        // Back-to-back samples, then stop at bit 10 of the second frame
        u0 = und_cnt[0]; p0 = pop_cnt[0];
        q0.push_back(32'h8000_7FFF);
        q0.push_back(32'h0001_FFFE);
        q0.push_back($urandom);
        en0 = 1'b1;
        step(344);
        check_eq("t3_underruns", und_cnt[0] - u0, 0);
        check_eq("t3_pops", pop_cnt[0] - p0, 3);

        // Disable mid-frame, hold retained, re-enable
        en0 = 1'b0;
        step(1);
        check_eq("t5_bclk_off", bclk0, 1'b0);
        check_eq("t5_lrclk_off", lr0, 1'b0);
        check_eq("t5_sdata_off", sd0, 1'b0);
        step(20);
        u0 = und_cnt[0]; p0 = pop_cnt[0];
        en0 = 1'b1;
        step(168);
        check_eq("t5_underruns", und_cnt[0] - u0, 0);
        check_eq("t5_pops", pop_cnt[0] - p0, 0);

        // Asynchronous reset at bit 20
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_bclk_async", bclk0, 1'b0);
        check_eq("t6_lrclk_async", lr0, 1'b0);
        check_eq("t6_sdata_async", sd0, 1'b0);
        check_eq("t6_underrun_async", und0, 1'b0);
        en0 = 1'b0;
        step(3);
        rst = 1'b0;
        step(2);
        p0 = pop_cnt[0];
        q0.push_back($urandom);
        en0 = 1'b1;
        step(280);
        check_eq("t6_pops", pop_cnt[0] - p0, 1);
        en0 = 1'b0;
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
